// File: rtl/rlbp_pkg.sv
// rlbp_pkg: FSM state encoding, timing-register index map and bus defaults shared by
// the RLBP configuration master and its shadow table.
package rlbp_pkg;

  localparam logic [31:0] RLBP_BASE_ADDR = 32'h3000_0000;
  localparam int          RLBP_NREGS     = 17;
  localparam int          RLBP_TIMEOUT   = 255;

  // Register index map; SR is the self-modifying shift register.
  localparam logic [4:0] VD1_UP   = 5'd0;
  localparam logic [4:0] VD1_DN   = 5'd1;
  localparam logic [4:0] VD2_UP   = 5'd2;
  localparam logic [4:0] VD2_DN   = 5'd3;
  localparam logic [4:0] VD3_UP   = 5'd4;
  localparam logic [4:0] VD3_DN   = 5'd5;
  localparam logic [4:0] VD4_UP   = 5'd6;
  localparam logic [4:0] VD4_DN   = 5'd7;
  localparam logic [4:0] RST_UP   = 5'd8;
  localparam logic [4:0] RST_DN   = 5'd9;
  localparam logic [4:0] TX_UP    = 5'd10;
  localparam logic [4:0] TX_DN    = 5'd11;
  localparam logic [4:0] SMP_UP   = 5'd12;
  localparam logic [4:0] SMP_DN   = 5'd13;
  localparam logic [4:0] TIME_RST = 5'd14;
  localparam logic [4:0] TIME_CMP = 5'd15;
  localparam logic [4:0] SR       = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP
  } state_e;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [4:0] idx);
    return base + {25'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/rlbp_cfg_shadow.sv
// rlbp_cfg_shadow: NREGS x 12-bit shadow of the timing registers; one write port,
// one combinational read port.
module rlbp_cfg_shadow
  import rlbp_pkg::*;
#(
  parameter int NREGS = RLBP_NREGS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  widx_i,
  input  logic [11:0] wdat_i,
  input  logic [4:0]  ridx_i,
  output logic [11:0] rdat_o
);

  logic [11:0] mem_q [NREGS];
  logic [11:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[widx_i] = wdat_i;
  end

  // NOTE: this table is small and must read back as zero after reset, so every
  // entry is reset; a large RAM would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdat_o = mem_q[ridx_i];

endmodule

// File: rtl/rlbp_cfg_master.sv
// rlbp_cfg_master: writes the shadow table to NREGS Wishbone registers on go_i.
// Define RLBP_CFG_READBACK_EN to add a readback pass that compares every register except SR.
module rlbp_cfg_master
  import rlbp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RLBP_BASE_ADDR,
  parameter int          NREGS     = RLBP_NREGS,
  parameter int          TIMEOUT   = RLBP_TIMEOUT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        go_i,
  input  logic        cfg_we_i,
  input  logic [4:0]  cfg_idx_i,
  input  logic [11:0] cfg_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [4:0]  err_idx_o
);

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);
  localparam logic [5:0] NREGS_W  = 6'(NREGS);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [4:0]  err_idx_q, err_idx_d;
  logic        done_q, done_d;
  logic [11:0] shadow_rdat;
  logic        shadow_we;
  logic        unused_dat;

  assign busy_o    = (state_q != ST_IDLE);
  assign shadow_we = cfg_we_i && !busy_o && ({1'b0, cfg_idx_i} < NREGS_W);

  rlbp_cfg_shadow #(.NREGS(NREGS)) u_shadow (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .we_i   (shadow_we),
    .widx_i (cfg_idx_i),
    .wdat_i (cfg_dat_i),
    .ridx_i (idx_q),
    .rdat_o (shadow_rdat)
  );

`ifdef RLBP_CFG_READBACK_EN
  logic rd_mismatch;
  assign rd_mismatch = (idx_q != SR) && (wbm_dat_i[11:0] != shadow_rdat);
  assign unused_dat  = ^wbm_dat_i[31:12];
`else
  assign unused_dat  = ^wbm_dat_i;
`endif

  // NOTE: every signal written here gets a default first so no path can infer a latch;
  // combinational blocks use blocking '=', the state register below uses '<='.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = '0;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'b0000;
    wbm_adr_o = '0;
    wbm_dat_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          state_d   = ST_WR_REQ;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      ST_WR_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'b0001;
        wbm_adr_o = reg_addr(BASE_ADDR, idx_q);
        wbm_dat_o = {20'b0, shadow_rdat};
        if (wbm_ack_i) begin
          state_d = ST_WR_GAP;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // The gap cycle swallows an ack a responder may still be holding from the last beat.
      ST_WR_GAP: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef RLBP_CFG_READBACK_EN
          state_d = ST_RD_REQ;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_WR_REQ;
        end
      end
`ifdef RLBP_CFG_READBACK_EN
      ST_RD_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'b0001;
        wbm_adr_o = reg_addr(BASE_ADDR, idx_q);
        if (wbm_ack_i) begin
          state_d = ST_RD_GAP;
          // Only the first mismatching index is reported.
          if (rd_mismatch && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RD_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_RD_REQ;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      done_q    <= done_d;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_rlbp_cfg_master.sv
// tb_rlbp_cfg_master: randomized bench for rlbp_cfg_master; a Wishbone responder plus a
// reference shadow table predict every bus transaction and the error outcome.
module tb_rlbp_cfg_master;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int          NREGS   = 17;
  localparam int          TIMEOUT = 255;

  typedef enum int {R_NORMAL, R_HOLD, R_STALL} resp_e;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        go_i;
  logic        cfg_we_i;
  logic [4:0]  cfg_idx_i;
  logic [11:0] cfg_dat_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o, done_o, err_o;
  logic [4:0]  err_idx_o;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] ref_shadow [NREGS];
  logic [11:0] corrupt    [NREGS];
  txn_t        log_q [$];
  resp_e       resp_mode = R_NORMAL;
  int          done_cnt = 0;
  int          stall_cycles = 0;

  rlbp_cfg_master #(.BASE_ADDR(BASE), .NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .go_i      (go_i),
    .cfg_we_i  (cfg_we_i),
    .cfg_idx_i (cfg_idx_i),
    .cfg_dat_i (cfg_dat_i),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_idx_o (err_idx_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic log_txn();
    log_q.push_back('{wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o});
  endtask

  // Responder: acks one cycle after a request appears, or holds ack high, or stalls idx3 writes.
  initial begin : responder
    bit          pend;
    int          ri;
    logic [31:0] rnd;
    pend      = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && wbm_stb_o) begin
        ri  = int'((wbm_adr_o - BASE) >> 2);
        rnd = $urandom();
        if (ri >= 0 && ri < NREGS) rnd[11:0] = ref_shadow[ri] ^ corrupt[ri];
        wbm_dat_i = rnd;
        if (resp_mode == R_HOLD) begin
          wbm_ack_i = 1'b1;
          log_txn();
        end else if (resp_mode == R_STALL && wbm_we_o && ri == 3) begin
          wbm_ack_i = 1'b0;
          stall_cycles++;
        end else if (pend) begin
          wbm_ack_i = 1'b1;
          log_txn();
        end else begin
          pend      = 1'b1;
          wbm_ack_i = 1'b0;
        end
      end else begin
        pend      = 1'b0;
        wbm_ack_i = (resp_mode == R_HOLD);
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge wb_clk_i);
      if (done_o) begin
        done_cnt++;
        check("done_drops_busy", {31'b0, busy_o}, 32'd0);
      end
    end
  end

  task automatic cfg_write(input logic [4:0] idx, input logic [11:0] dat);
    @(negedge wb_clk_i);
    cfg_we_i  = 1'b1;
    cfg_idx_i = idx;
    cfg_dat_i = dat;
    @(negedge wb_clk_i);
    cfg_we_i  = 1'b0;
    if (int'(idx) < NREGS) ref_shadow[idx] = dat;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_o && n < 20000) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 20000) check({name, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge wb_clk_i);
  endtask

  task automatic start_go();
    done_cnt = 0;
    log_q.delete();
    @(negedge wb_clk_i);
    go_i = 1'b1;
    @(negedge wb_clk_i);
    go_i = 1'b0;
  endtask

  // Full sequence: expected bus traffic and error outcome are derived from the reference table.
  task automatic run_seq(input string name, input bit poke_busy);
    txn_t       exp_q [$];
    bit         exp_err;
    logic [4:0] exp_idx;
    int         n;
    exp_err = 1'b0;
    exp_idx = '0;
    for (int i = 0; i < NREGS; i++)
      exp_q.push_back('{1'b1, BASE + 32'(4 * i), {20'b0, ref_shadow[i]}, 4'b0001});
`ifdef RLBP_CFG_READBACK_EN
    for (int i = 0; i < NREGS; i++) begin
      exp_q.push_back('{1'b0, BASE + 32'(4 * i), 32'd0, 4'b0001});
      if (i != 16 && corrupt[i] != 12'h0 && !exp_err) begin
        exp_err = 1'b1;
        exp_idx = 5'(i);
      end
    end
`endif
    start_go();
    check({name, "_busy"}, {31'b0, busy_o}, 32'd1);
    if (poke_busy) begin
      cfg_we_i  = 1'b1;
      cfg_idx_i = 5'd10;
      cfg_dat_i = ~ref_shadow[10];
      go_i      = 1'b1;
      @(negedge wb_clk_i);
      cfg_we_i  = 1'b0;
      go_i      = 1'b0;
    end
    wait_done(name);
    check({name, "_done_once"}, 32'(done_cnt), 32'd1);
    check({name, "_ntxn"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_we%0d", name, k), {31'b0, log_q[k].we}, {31'b0, exp_q[k].we});
      check($sformatf("%s_adr%0d", name, k), log_q[k].adr, exp_q[k].adr);
      check($sformatf("%s_sel%0d", name, k), {28'b0, log_q[k].sel}, {28'b0, exp_q[k].sel});
      if (exp_q[k].we) check($sformatf("%s_dat%0d", name, k), log_q[k].dat, exp_q[k].dat);
    end
    check({name, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    check({name, "_err_idx"}, {27'b0, err_idx_o}, {27'b0, exp_idx});
    check({name, "_cyc_idle"}, {31'b0, wbm_cyc_o}, 32'd0);
  endtask

  initial begin : main
    int n;
    wb_rst_i  = 1'b1;
    go_i      = 1'b0;
    cfg_we_i  = 1'b0;
    cfg_idx_i = '0;
    cfg_dat_i = '0;
    for (int i = 0; i < NREGS; i++) begin
      ref_shadow[i] = '0;
      corrupt[i]    = '0;
    end
    #1;
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'b0, wbm_we_o}, 32'd0);
    check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_err_idx", {27'b0, err_idx_o}, 32'd0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Random table contents, including indices beyond the table; busy-time writes/go ignored.
    for (int k = 0; k < 40; k++) cfg_write(5'($urandom_range(0, 31)), 12'($urandom()));
    run_seq("rand", 1'b1);
    run_seq("rand_again", 1'b0);

    for (int i = 0; i < NREGS; i++) cfg_write(5'(i), 12'h010 + 12'(i));
    run_seq("directed", 1'b0);

    // Corrupted readback of idx5 (reads 12'hFFF), later idx9, and the excluded SR.
    corrupt[5]  = ref_shadow[5] ^ 12'hFFF;
    corrupt[9]  = 12'h001;
    corrupt[16] = 12'h5A5;
    run_seq("corrupt", 1'b0);
    for (int i = 0; i < NREGS; i++) corrupt[i] = '0;
    run_seq("clean", 1'b0);

    // Responder never acks the idx3 write.
    resp_mode    = R_STALL;
    stall_cycles = 0;
    start_go();
    wait_done("stall");
    check("stall_req_cycles", 32'(stall_cycles), 32'(TIMEOUT));
    check("stall_ntxn", 32'(log_q.size()), 32'd3);
    check("stall_err", {31'b0, err_o}, 32'd1);
    check("stall_err_idx", {27'b0, err_idx_o}, 32'd3);
    check("stall_done_once", 32'(done_cnt), 32'd1);
    check("stall_cyc_low", {31'b0, wbm_cyc_o}, 32'd0);

    // Ack held high throughout: each beat must be exactly one request cycle.
    resp_mode = R_HOLD;
    for (int k = 0; k < 5; k++) cfg_write(5'($urandom_range(0, 16)), 12'($urandom()));
    run_seq("hold", 1'b0);
    resp_mode = R_NORMAL;
    @(negedge wb_clk_i);

    // Reset while the idx7 write is on the bus.
    start_go();
    n = 0;
    while (!(wbm_cyc_o && wbm_we_o && wbm_adr_o == BASE + 32'd28) && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("midrst_reached_idx7", {31'b0, (n < 2000)}, 32'd1);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("midrst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    for (int i = 0; i < NREGS; i++) ref_shadow[i] = '0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    run_seq("after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rlbp_cfg_master.md
RLBP_CFG_MASTER -- requirements
Module: rlbp_cfg_master

Interface
REQ-001 SHALL use parameter BASE_ADDR, default 32'h3000_0000, word address of timing register 0 on the Wishbone bus.
REQ-002 SHALL use parameter NREGS, default 17, number of consecutive word registers to program (indices 0..NREGS-1, index 16 = shift register).
REQ-003 SHALL use parameter TIMEOUT, default 255, maximum cycles to wait for ack per transaction.
REQ-004 SHALL have wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have wb_rst_i  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have go_i  in  1  start pulse for a programming sequence.
REQ-007 SHALL have cfg_we_i  in  1  shadow table write strobe.
REQ-008 SHALL have cfg_idx_i  in  5  shadow table index.
REQ-009 SHALL have cfg_dat_i  in  12  shadow table write data.
REQ-010 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone initiator controls.
REQ-011 SHALL have wbm_sel_o  out  4, wbm_adr_o  out  32, wbm_dat_o  out  32  Wishbone initiator select, address, write data.
REQ-012 SHALL have wbm_dat_i  in  32, wbm_ack_i  in  1  Wishbone responder data and ack.
REQ-013 SHALL have busy_o  out  1 sequence active; done_o  out  1 one-cycle completion pulse; err_o  out  1 sticky error; err_idx_o  out  5 failing index.

Function
REQ-014 SHALL hold a shadow table of NREGS x 12 bits, written when cfg_we_i=1, busy_o=0 and cfg_idx_i<NREGS; all other cfg writes are ignored.
REQ-015 SHALL implement states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP.
REQ-016 IDLE: go_i=1 -> WR_REQ with idx=0, err_o cleared, busy_o=1; go_i while busy is ignored.
REQ-017 WR_REQ SHALL drive cyc=stb=we=1, sel=4'b0001, adr=BASE_ADDR+4*idx, dat={20'b0,shadow[idx]}.
REQ-018 On the edge that samples wbm_ack_i=1 in a REQ state, cyc/stb SHALL deassert the next cycle and the FSM enters the matching GAP state.
REQ-019 GAP states SHALL last exactly one cycle with cyc/stb low and wbm_ack_i ignored (stale responder ack), then advance idx.
REQ-020 After WR_GAP of idx=NREGS-1, SHALL enter RD_REQ with idx=0 when readback is compiled in, else IDLE.
REQ-021 RD_REQ SHALL drive cyc=stb=1, we=0, sel=4'b0001, same address rule; on ack, wbm_dat_i[11:0] SHALL be compared to shadow[idx].
REQ-022 Index 16 (shift register, self-modifying) SHALL be excluded from readback compare.
REQ-023 Compare mismatch SHALL set err_o=1, err_idx_o=idx, and the sequence continues to completion (first mismatch index kept).
REQ-024 A 8-bit per-transaction counter SHALL clear on REQ entry; reaching TIMEOUT without ack SHALL drop cyc/stb, set err_o, err_idx_o=idx, and return to IDLE.
REQ-025 Every return to IDLE from a non-IDLE state SHALL pulse done_o for exactly one cycle and drop busy_o in that same cycle.
REQ-026 err_o and err_idx_o SHALL hold until the next accepted go_i.

Reset
REQ-027 On wb_rst_i=1, asynchronously: state=IDLE, idx=0, all wbm_* outputs 0, busy_o=done_o=err_o=0, err_idx_o=0, shadow table all zero.
REQ-028 Reset asserted mid-transaction SHALL drop cyc/stb immediately without waiting for ack.

Configuration
REQ-029 Macro RLBP_CFG_READBACK_EN defined: RD_REQ/RD_GAP and compare logic present; undefined: FSM goes IDLE after last write, err_o set only by timeout.

Structure
REQ-030 Shared package rlbp_pkg SHALL hold the FSM state encoding, register index constants (VD1_UP=0 ... TIME_CMP=15, SR=16), and default BASE_ADDR.
REQ-031 The shadow table SHALL be a sub-module rlbp_cfg_shadow (write port, one combinational read port).

Verification
REQ-032 Load idx0..16 with 12'h010+idx, go_i, responder acks after 1 cycle -> 17 writes at 0x3000_0000..0x3000_0040, data 0x010..0x020, done_o once.
REQ-033 Readback enabled, responder returns written data -> 16 compares pass, err_o=0; corrupt idx5 read to 12'hFFF -> err_o=1, err_idx_o=5.
REQ-034 Responder never acks idx3 -> cyc low after 255 cycles, err_o=1, err_idx_o=3, done_o pulse.
REQ-035 Responder holds ack high continuously -> each transaction still one REQ + one GAP cycle, exactly 17 writes issued.
REQ-036 wb_rst_i asserted during WR_REQ idx7 -> cyc/stb low same cycle, busy_o=0; go_i while busy and cfg_we_i while busy -> no effect.
